// File: rtl/emulib_rammodel_a_arbiter.sv
// Round-robin arbiter that forwards whole A-channel packets from N_PORTS requester
// word streams to one decoder stream. Optional ID tagging under RAMMODEL_ARB_TAG_EN.
module emulib_rammodel_a_arbiter #(
    parameter int  N_PORTS    = 2,
    parameter int  ADDR_WIDTH = 32,
    localparam int SEL_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_PORTS-1:0]    s_valid,
    output logic [N_PORTS-1:0]    s_ready,
    input  logic [32*N_PORTS-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [31:0]           m_data,
    output logic [SEL_W-1:0]      grant_idx,
    output logic                  idle
);

    localparam int         PKT_WORDS = (ADDR_WIDTH <= 32) ? 2 : 3;
    localparam logic [1:0] LAST_WORD = 2'(PKT_WORDS - 1);

    typedef enum logic {ARB, XFER} state_e;

    state_e           state_q;
    logic [SEL_W-1:0] rr_ptr_q;
    logic [SEL_W-1:0] rr_ptr_d;
    logic [SEL_W-1:0] grant_q;
    logic [1:0]       word_cnt_q;
    logic             idle_q;

    logic             arb_hit;
    logic [SEL_W-1:0] arb_sel;
    logic             xfer;
    logic             fire;
    logic [31:0]      s_word;
    logic [31:0]      s_words [N_PORTS];

    for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
        assign s_words[i] = s_data[32*i +: 32];
    end

    // Scan from the far end back towards rr_ptr so the closest requester wins last.
    always_comb begin
        arb_hit = 1'b0;
        arb_sel = rr_ptr_q;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (s_valid[(int'(rr_ptr_q) + k) % N_PORTS]) begin
                arb_hit = 1'b1;
                arb_sel = SEL_W'((int'(rr_ptr_q) + k) % N_PORTS);
            end
        end
    end

    assign rr_ptr_d = (grant_q == SEL_W'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;

    // Handshake outputs are forced low while rst is held so no word is consumed.
    assign xfer    = (state_q == XFER) && !rst;
    assign s_word  = s_words[grant_q];
    assign m_valid = xfer && s_valid[grant_q];
    assign fire    = m_valid && m_ready;

    always_comb begin
        s_ready = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (xfer && m_ready && (grant_q == SEL_W'(i))) begin
                s_ready[i] = 1'b1;
            end
        end
    end

`ifdef RAMMODEL_ARB_TAG_EN
    logic [31:0] tag_wide;

    // Header ID gets the port index appended; bits shifted past 15 are dropped.
    always_comb begin
        tag_wide = ({16'h0000, s_word[31:16]} << SEL_W) | 32'(grant_q);
        m_data   = s_word;
        if (word_cnt_q == 2'd0) begin
            m_data[31:16] = tag_wide[15:0];
        end
    end
`else
    assign m_data = s_word;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            word_cnt_q <= 2'd0;
            idle_q     <= 1'b1;
        end else begin
            case (state_q)
                ARB: begin
                    if (arb_hit) begin
                        grant_q    <= arb_sel;
                        word_cnt_q <= 2'd0;
                        state_q    <= XFER;
                        idle_q     <= 1'b0;
                    end
                end
                XFER: begin
                    if (fire) begin
                        if (word_cnt_q == LAST_WORD) begin
                            state_q  <= ARB;
                            idle_q   <= 1'b1;
                            rr_ptr_q <= rr_ptr_d;
                        end else begin
                            word_cnt_q <= word_cnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ARB;
                    idle_q  <= 1'b1;
                end
            endcase
        end
    end

    assign grant_idx = grant_q;
    assign idle      = idle_q;

endmodule

// File: tb/tb_emulib_rammodel_a_arbiter.sv
// Scoreboard bench: two arbiter instances (2 ports/32-bit addr, 4 ports/40-bit addr)
// fed by queue-driven requesters; a negedge monitor pops expected words on each fire.
module tb_emulib_rammodel_a_arbiter;
    localparam int NA = 2;
    localparam int NB = 4;
`ifdef RAMMODEL_ARB_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a, mv_a, mr_a, idle_a;
    logic [NA-1:0]   sv_a, sr_a;
    logic [32*NA-1:0] sd_a;
    logic [31:0]     md_a;
    logic [0:0]      gi_a;

    logic            rst_b, mv_b, mr_b, idle_b;
    logic [NB-1:0]   sv_b, sr_b;
    logic [32*NB-1:0] sd_b;
    logic [31:0]     md_b;
    logic [1:0]      gi_b;

    emulib_rammodel_a_arbiter #(.N_PORTS(NA), .ADDR_WIDTH(32)) u_dut_a (
        .clk(clk), .rst(rst_a), .s_valid(sv_a), .s_ready(sr_a), .s_data(sd_a),
        .m_valid(mv_a), .m_ready(mr_a), .m_data(md_a), .grant_idx(gi_a), .idle(idle_a)
    );

    emulib_rammodel_a_arbiter #(.N_PORTS(NB), .ADDR_WIDTH(40)) u_dut_b (
        .clk(clk), .rst(rst_b), .s_valid(sv_b), .s_ready(sr_b), .s_data(sd_b),
        .m_valid(mv_b), .m_ready(mr_b), .m_data(md_b), .grant_idx(gi_b), .idle(idle_b)
    );

    logic [31:0] wq_a [NA][$];
    logic [31:0] wq_b [NB][$];
    exp_t        eq_a [$];
    exp_t        eq_b [$];
    exp_t        ea, eb;
    logic        rst_cmd_a = 1'b1, rst_cmd_b = 1'b1;
    logic        mr_cmd_a = 1'b1, mr_cmd_b = 1'b1;
    int          nvec = 0;
    int          nerr = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
        end
    endtask

    // Requesters: hold each word until it fires; a reset flushes any partial packet.
    initial begin : drv_a
        logic [NA-1:0] fire;
        rst_a = 1'b1; mr_a = 1'b1; sv_a = '0; sd_a = '0;
        forever begin
            @(negedge clk);
            fire = sv_a & sr_a;
            @(posedge clk);
            #1;
            for (int i = 0; i < NA; i++) begin
                if (rst_cmd_a) wq_a[i].delete();
                else if (fire[i]) void'(wq_a[i].pop_front());
                sv_a[i] = (wq_a[i].size() != 0);
                sd_a[32*i +: 32] = sv_a[i] ? wq_a[i][0] : 32'h0;
            end
            rst_a = rst_cmd_a;
            mr_a  = mr_cmd_a;
        end
    end

    initial begin : drv_b
        logic [NB-1:0] fire;
        rst_b = 1'b1; mr_b = 1'b1; sv_b = '0; sd_b = '0;
        forever begin
            @(negedge clk);
            fire = sv_b & sr_b;
            @(posedge clk);
            #1;
            for (int i = 0; i < NB; i++) begin
                if (rst_cmd_b) wq_b[i].delete();
                else if (fire[i]) void'(wq_b[i].pop_front());
                sv_b[i] = (wq_b[i].size() != 0);
                sd_b[32*i +: 32] = sv_b[i] ? wq_b[i][0] : 32'h0;
            end
            rst_b = rst_cmd_b;
            mr_b  = mr_cmd_b;
        end
    end

    always @(negedge clk) begin
        if (mv_a && mr_a) begin
            if (eq_a.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL a_unexpected: got %08h grant %0d, expected no word", md_a, gi_a);
            end else begin
                ea = eq_a.pop_front();
                cmp("a_data", md_a, ea.data);
                cmp("a_grant", 32'(gi_a), 32'(ea.sel));
            end
        end
    end

    always @(negedge clk) begin
        if (mv_b && mr_b) begin
            if (eq_b.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL b_unexpected: got %08h grant %0d, expected no word", md_b, gi_b);
            end else begin
                eb = eq_b.pop_front();
                cmp("b_data", md_b, eb.data);
                cmp("b_grant", 32'(gi_b), 32'(eb.sel));
            end
        end
    end

    task automatic push_a(input int p, input logic [31:0] hdr, input logic [31:0] addr,
                          input logic [1:0] sel, input logic [31:0] tag_hdr, input bit exp_addr);
        wq_a[p].push_back(hdr);
        wq_a[p].push_back(addr);
        eq_a.push_back({sel, (TAG_EN ? tag_hdr : hdr)});
        if (exp_addr) eq_a.push_back({sel, addr});
    endtask

    task automatic push_b(input int p, input logic [31:0] hdr, input logic [31:0] a0,
                          input logic [31:0] a1, input logic [1:0] sel, input logic [31:0] tag_hdr);
        wq_b[p].push_back(hdr);
        wq_b[p].push_back(a0);
        wq_b[p].push_back(a1);
        eq_b.push_back({sel, (TAG_EN ? tag_hdr : hdr)});
        eq_b.push_back({sel, a0});
        eq_b.push_back({sel, a1});
    endtask

    task automatic wait_empty(input int which, input int budget, output int cyc);
        cyc = 0;
        while (((which == 0) ? eq_a.size() : eq_b.size()) != 0 && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (((which == 0) ? eq_a.size() : eq_b.size()) != 0) begin
            nvec++; nerr++;
            $display("FAIL drain_%0d: %0d words outstanding after %0d cycles, expected 0",
                     which, (which == 0) ? eq_a.size() : eq_b.size(), cyc);
        end
    endtask

    initial begin : stim
        int cyc;
        repeat (3) @(negedge clk);
        rst_cmd_a = 1'b0;
        rst_cmd_b = 1'b0;

        // Reset, then idle with no requests.
        repeat (10) begin
            @(negedge clk);
            cmp("t1_mvalid_a", mv_a, 0);
            cmp("t1_idle_a", idle_a, 1);
            cmp("t1_grant_a", gi_a, 0);
            cmp("t1_mvalid_b", mv_b, 0);
            cmp("t1_idle_b", idle_b, 1);
            cmp("t1_grant_b", gi_b, 0);
        end

        // Single packet on port1: bubble, two consecutive words, back to idle.
        @(negedge clk);
        push_a(1, 32'h0003_0F41, 32'h8000_1000, 2'd1, 32'h0007_0F41, 1'b1);
        @(negedge clk);
        cmp("t2_bubble_mvalid", mv_a, 0);
        cmp("t2_bubble_idle", idle_a, 1);
        @(negedge clk);
        cmp("t2_hdr_mvalid", mv_a, 1);
        cmp("t2_hdr_grant", gi_a, 1);
        cmp("t2_hdr_idle", idle_a, 0);
        @(negedge clk);
        cmp("t2_addr_mvalid", mv_a, 1);
        @(negedge clk);
        cmp("t2_done_idle", idle_a, 1);
        cmp("t2_done_mvalid", mv_a, 0);
        wait_empty(0, 20, cyc);

        // Contention: two packets per port, grants alternate 0,1,0,1 at 2 words per 3 cycles.
        @(negedge clk);
        wq_a[0].push_back(32'h0011_0100); wq_a[0].push_back(32'hA000_0000);
        wq_a[0].push_back(32'h0012_0101); wq_a[0].push_back(32'hA000_0040);
        wq_a[1].push_back(32'h0021_0200); wq_a[1].push_back(32'hB000_0000);
        wq_a[1].push_back(32'h0022_0201); wq_a[1].push_back(32'hB000_0040);
        eq_a.push_back({2'd0, (TAG_EN ? 32'h0022_0100 : 32'h0011_0100)});
        eq_a.push_back({2'd0, 32'hA000_0000});
        eq_a.push_back({2'd1, (TAG_EN ? 32'h0043_0200 : 32'h0021_0200)});
        eq_a.push_back({2'd1, 32'hB000_0000});
        eq_a.push_back({2'd0, (TAG_EN ? 32'h0024_0101 : 32'h0012_0101)});
        eq_a.push_back({2'd0, 32'hA000_0040});
        eq_a.push_back({2'd1, (TAG_EN ? 32'h0045_0201 : 32'h0022_0201)});
        eq_a.push_back({2'd1, 32'hB000_0040});
        wait_empty(0, 40, cyc);
        cmp("t3_cycles", cyc, 12);

        // Backpressure after the header fire while port0 also requests.
        @(negedge clk);
        push_a(1, 32'h0031_0300, 32'hB000_0080, 2'd1, 32'h0063_0300, 1'b1);
        @(negedge clk);
        push_a(0, 32'h0013_0102, 32'hA000_0080, 2'd0, 32'h0026_0102, 1'b1);
        @(negedge clk);
        cmp("t4_hdr_grant", gi_a, 1);
        cmp("t4_hdr_mvalid", mv_a, 1);
        mr_cmd_a = 1'b0;
        repeat (5) begin
            @(negedge clk);
            cmp("t4_hold_data", md_a, 32'hB000_0080);
            cmp("t4_hold_grant", gi_a, 1);
            cmp("t4_hold_mvalid", mv_a, 1);
            cmp("t4_hold_sready0", sr_a[0], 0);
            cmp("t4_hold_sready1", sr_a[1], 0);
        end
        mr_cmd_a = 1'b1;
        wait_empty(0, 30, cyc);

        // Reset right after a header fire: addr word is dropped, pointer returns to 0.
        @(negedge clk);
        push_a(0, 32'h0014_0103, 32'hA000_00C0, 2'd0, 32'h0028_0103, 1'b0);
        @(negedge clk);
        @(negedge clk);
        cmp("t6_hdr_mvalid", mv_a, 1);
        rst_cmd_a = 1'b1;
        @(negedge clk);
        cmp("t6_rst_mvalid", mv_a, 0);
        rst_cmd_a = 1'b0;
        @(negedge clk);
        cmp("t6_rst_idle", idle_a, 1);
        cmp("t6_rst_grant", gi_a, 0);
        cmp("t6_rst_mvalid2", mv_a, 0);
        cmp("t6_rst_drained", eq_a.size(), 0);
        @(negedge clk);
        push_a(0, 32'h0015_0104, 32'hA000_0100, 2'd0, 32'h002A_0104, 1'b1);
        push_a(1, 32'h0023_0202, 32'hB000_0100, 2'd1, 32'h0047_0202, 1'b1);
        wait_empty(0, 30, cyc);

        // 40-bit address: three-word packet on port3, then back to ARB.
        @(negedge clk);
        push_b(3, 32'h0001_0021, 32'h0000_2000, 32'h0000_0012, 2'd3, 32'h0007_0021);
        @(negedge clk);
        cmp("t5_bubble_mvalid", mv_b, 0);
        repeat (3) begin
            @(negedge clk);
            cmp("t5_word_mvalid", mv_b, 1);
            cmp("t5_word_grant", gi_b, 3);
        end
        @(negedge clk);
        cmp("t5_done_idle", idle_b, 1);
        cmp("t5_done_mvalid", mv_b, 0);
        wait_empty(1, 20, cyc);

        // Port2 header id 0x0005 (tagged to 0x0016 when tagging is built in).
        @(negedge clk);
        push_b(2, 32'h0005_0021, 32'h0000_3000, 32'h0000_0001, 2'd2, 32'h0016_0021);
        wait_empty(1, 20, cyc);

        // Pointer at 3: port3 before port0; port0 id 0x4001 loses its top bits when tagged.
        @(negedge clk);
        push_b(3, 32'h0007_0021, 32'h0000_5000, 32'h0000_0002, 2'd3, 32'h001F_0021);
        push_b(0, 32'h4001_0021, 32'h0000_4000, 32'h0000_0000, 2'd0, 32'h0004_0021);
        wait_empty(1, 30, cyc);

        repeat (3) @(negedge clk);
        cmp("end_idle_a", idle_a, 1);
        cmp("end_idle_b", idle_b, 1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
